// File: rtl/game_round_controller_if.sv
// Button/LFSR/sensor inputs and round-status outputs of the whack-a-mole round controller.
// master = the controller, slave = the board-side environment driving buttons and sensors.
interface game_round_controller_if;
    logic       start_btn;
    logic [2:0] lfsr_value;
    logic       sensor_hit;
    logic [2:0] sensor_box;
    logic       start_game;
    logic [2:0] target_box;
    logic       target_valid;
    logic       hit_detected;
    logic       miss_pulse;
    logic [1:0] difficulty_level;
    logic [7:0] round_count;
    logic [6:0] time_left_s;
    logic       game_over;

    modport master (
        input  start_btn, lfsr_value, sensor_hit, sensor_box,
        output start_game, target_box, target_valid, hit_detected, miss_pulse,
               difficulty_level, round_count, time_left_s, game_over
    );

    modport slave (
        output start_btn, lfsr_value, sensor_hit, sensor_box,
        input  start_game, target_box, target_valid, hit_detected, miss_pulse,
               difficulty_level, round_count, time_left_s, game_over
    );
endinterface

// File: rtl/game_round_controller.sv
// Whack-a-mole round sequencer: start -> arm -> hit window -> cooldown until game time runs out.
// Optional GAME_CTRL_DEBOUNCE_EN: sensor_hit must be stable high 16 clocks before a strike is accepted.
module game_round_controller #(
    parameter int TICK_DIV    = 50_000,
    parameter int GAME_MS     = 60_000,
    parameter int LVL2_MS     = 20_000,
    parameter int LVL3_MS     = 40_000,
    parameter int WIN_L1_MS   = 1500,
    parameter int WIN_L2_MS   = 1000,
    parameter int WIN_L3_MS   = 600,
    parameter int COOLDOWN_MS = 250,
    parameter int NUM_BOXES   = 6
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    game_round_controller_if.master  io
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = $clog2(GAME_MS + 1);
    localparam int RW = $clog2(WIN_L1_MS + WIN_L2_MS + WIN_L3_MS + COOLDOWN_MS + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_HIT, S_COOLDOWN, S_OVER} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [MW-1:0] ms_left_q, ms_left_d, elapsed_q, elapsed_d;
    logic [9:0]    msec_q, msec_d;
    logic [6:0]    sec_q, sec_d;
    logic [RW-1:0] rtmr_q, rtmr_d;
    logic [2:0]    target_q, target_d, prev_q, prev_d;
    logic [7:0]    round_q, round_d;
    logic          hit_q, hit_d, miss_q, miss_d;
    logic          start_q;
    logic          in_game, tick, start_edge, hit_edge, lfsr_ok, enter_cool;
    logic [1:0]    diff;
    logic [RW-1:0] win_len;

    assign in_game    = (state_q == S_ARM) || (state_q == S_WAIT_HIT) || (state_q == S_COOLDOWN);
    assign tick       = in_game && (tick_cnt_q == TW'(TICK_DIV - 1));
    assign start_edge = io.start_btn & ~start_q;
    assign lfsr_ok    = (int'(io.lfsr_value) < NUM_BOXES) && (io.lfsr_value != prev_q);

    assign diff    = (int'(elapsed_q) < LVL2_MS) ? 2'd1 :
                     (int'(elapsed_q) < LVL3_MS) ? 2'd2 : 2'd3;
    assign win_len = (diff == 2'd1) ? RW'(WIN_L1_MS) :
                     (diff == 2'd2) ? RW'(WIN_L2_MS) : RW'(WIN_L3_MS);

`ifdef GAME_CTRL_DEBOUNCE_EN
    // acc_q marks that the current high period has already produced its strike
    logic [3:0] stable_q;
    logic       acc_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            stable_q <= 4'd0;
            acc_q    <= 1'b0;
        end else if (!io.sensor_hit) begin
            stable_q <= 4'd0;
            acc_q    <= 1'b0;
        end else begin
            if (stable_q != 4'hf) stable_q <= stable_q + 4'd1;
            if (stable_q == 4'hf) acc_q    <= 1'b1;
        end
    end

    assign hit_edge = io.sensor_hit & (stable_q == 4'hf) & ~acc_q;
`else
    logic sens_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) sens_q <= 1'b0;
        else       sens_q <= io.sensor_hit;
    end

    assign hit_edge = io.sensor_hit & ~sens_q;
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        ms_left_d  = ms_left_q;
        elapsed_d  = elapsed_q;
        msec_d     = msec_q;
        sec_d      = sec_q;
        rtmr_d     = rtmr_q;
        target_d   = target_q;
        prev_d     = prev_q;
        round_d    = round_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        enter_cool = 1'b0;

        if (in_game) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            if (tick && ms_left_q != '0) begin
                ms_left_d = ms_left_q - 1'b1;
                elapsed_d = elapsed_q + 1'b1;
                // seconds counter avoids a divider on ms_left
                if (msec_q == 10'd999) begin
                    msec_d = '0;
                    if (sec_q != '0) sec_d = sec_q - 1'b1;
                end else begin
                    msec_d = msec_q + 1'b1;
                end
            end
        end

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    state_d    = S_ARM;
                    tick_cnt_d = '0;
                    ms_left_d  = MW'(GAME_MS);
                    elapsed_d  = '0;
                    msec_d     = '0;
                    sec_d      = 7'(GAME_MS / 1000);
                    round_d    = '0;
                end
            end
            S_ARM: begin
                if (ms_left_q == '0) begin
                    state_d = S_OVER;
                end else if (!io.sensor_hit && lfsr_ok) begin
                    target_d = io.lfsr_value;
                    rtmr_d   = win_len;
                    state_d  = S_WAIT_HIT;
                end
            end
            S_WAIT_HIT: begin
                // a strike on the expiry tick is still a strike
                if (ms_left_q == '0) begin
                    state_d = S_OVER;
                end else if (hit_edge) begin
                    hit_d      = (io.sensor_box == target_q);
                    miss_d     = (io.sensor_box != target_q);
                    enter_cool = 1'b1;
                end else if (tick) begin
                    if (rtmr_q <= RW'(1)) begin
                        miss_d     = 1'b1;
                        enter_cool = 1'b1;
                    end else begin
                        rtmr_d = rtmr_q - 1'b1;
                    end
                end
            end
            S_COOLDOWN: begin
                if (ms_left_q == '0) begin
                    state_d = S_OVER;
                end else if (tick) begin
                    if (rtmr_q <= RW'(1)) state_d = S_ARM;
                    else                  rtmr_d  = rtmr_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_cool) begin
            state_d = S_COOLDOWN;
            rtmr_d  = RW'(COOLDOWN_MS);
            prev_d  = target_q;
            if (round_q != 8'hff) round_d = round_q + 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            tick_cnt_q <= '0;
            ms_left_q  <= '0;
            elapsed_q  <= '0;
            msec_q     <= '0;
            sec_q      <= '0;
            rtmr_q     <= '0;
            target_q   <= 3'd0;
            prev_q     <= 3'd7;
            round_q    <= 8'd0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= io.start_btn;
            tick_cnt_q <= tick_cnt_d;
            ms_left_q  <= ms_left_d;
            elapsed_q  <= elapsed_d;
            msec_q     <= msec_d;
            sec_q      <= sec_d;
            rtmr_q     <= rtmr_d;
            target_q   <= target_d;
            prev_q     <= prev_d;
            round_q    <= round_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign io.start_game       = in_game;
    assign io.target_box       = target_q;
    assign io.target_valid     = (state_q == S_WAIT_HIT);
    assign io.hit_detected     = hit_q;
    assign io.miss_pulse       = miss_q;
    assign io.difficulty_level = diff;
    assign io.round_count      = round_q;
    assign io.time_left_s      = sec_q;
    assign io.game_over        = (state_q == S_OVER);
endmodule

// File: tb/tb_game_round_controller.sv
// Randomized bench for game_round_controller: round outcomes and timing are predicted from the
// game rules (ms ticks every TD clocks from game start) and compared cycle by cycle.
module tb_game_round_controller;
    localparam int TD = 4, GMS = 200, L2 = 60, L3 = 120;
    localparam int W1 = 20, W2 = 15, W3 = 10, CD = 5, NB = 6;
    localparam int K_HIT = 0, K_WRONG = 1, K_TIMEOUT = 2, K_TIE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_round_controller_if io();

    game_round_controller #(
        .TICK_DIV(TD), .GAME_MS(GMS), .LVL2_MS(L2), .LVL3_MS(L3),
        .WIN_L1_MS(W1), .WIN_L2_MS(W2), .WIN_L3_MS(W3),
        .COOLDOWN_MS(CD), .NUM_BOXES(NB)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .io      (io)
    );

    int checks = 0, errors = 0;
    int gcyc;                       // clocks since the game-start edge
    int L, X, W, cur_tgt, prev_t, rounds_m;
    logic [1:0] diff_log [0:1023];
    bit         log_v    [0:1023];

    // difficulty from elapsed whole ms at sample n of the game
    function automatic int exp_diff(input int n);
        int el;
        el = n / TD;
        if (el > GMS) el = GMS;
        if (el < L2) return 1;
        if (el < L3) return 2;
        return 3;
    endfunction

    function automatic int win_of(input int d);
        return (d == 1) ? W1 : (d == 2) ? W2 : W3;
    endfunction

    function automatic int rand_tgt();
        int t;
        do t = $urandom_range(0, NB - 1); while (t == prev_t);
        return t;
    endfunction

    task automatic step();
        @(posedge clk); #1;
        gcyc++;
        if (gcyc >= 0 && gcyc < 1024) begin
            diff_log[gcyc] = io.difficulty_level;
            log_v[gcyc]    = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        io.start_btn = 1'b0; io.lfsr_value = 3'd0; io.sensor_hit = 1'b0; io.sensor_box = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        prev_t = 7; rounds_m = 0; gcyc = -100;
    endtask

    task automatic press_start();
        io.start_btn = 1'b1;
        @(posedge clk); #1;
        io.start_btn = 1'b0;
        gcyc = 0; rounds_m = 0;
        foreach (log_v[i]) log_v[i] = 1'b0;
        diff_log[0] = io.difficulty_level;
        log_v[0]    = 1'b1;
    endtask

    // from ARM: present target t, expect it latched on the next edge
    task automatic arm_round(input int t);
        io.lfsr_value = 3'(t);
        io.sensor_hit = 1'b0;
        step();
        L = gcyc; cur_tgt = t;
        W = win_of(exp_diff(L - 1));
        X = (L / TD + W) * TD;
        checks++;
        if (io.target_valid !== 1'b1 || io.target_box !== 3'(t)) begin
          errors++;
          $display("FAIL arm_load: target_valid=%0b target_box=%0d, expected 1/%0d",
                   io.target_valid, io.target_box, t);
        end
        io.lfsr_value = 3'((t + 1 + $urandom_range(0, NB - 2)) % NB);
    endtask

    task automatic finish_round(input int kind, input int s_force, input int box_force);
        int s, p, c, box, stray;
        logic eh, em;
        s = -1;
        if (kind == K_TIE) s = X - 1;
        else if (kind != K_TIMEOUT) s = (s_force >= 0) ? s_force : L + $urandom_range(0, X - L - 2);
        if (kind == K_WRONG)
            box = (box_force >= 0) ? box_force : (cur_tgt + 1 + $urandom_range(0, NB - 2)) % NB;
        else
            box = cur_tgt;
        p  = (kind == K_TIMEOUT) ? X : s + 1;
        c  = (p / TD + CD) * TD;
        eh = (kind == K_HIT || kind == K_TIE);
        em = (kind == K_WRONG || kind == K_TIMEOUT);
        stray = 0;
        while (gcyc < c) begin
            if (gcyc == s) begin io.sensor_hit = 1'b1; io.sensor_box = 3'(box); end
            step();
            if (gcyc == p) begin
                checks++;
                if (io.hit_detected !== eh || io.miss_pulse !== em) begin
                    errors++;
                    $display("FAIL round_pulse kind=%0d: hit=%0b miss=%0b, expected %0b/%0b",
                             kind, io.hit_detected, io.miss_pulse, eh, em);
                end
                if (rounds_m < 255) rounds_m++;
                checks++;
                if (io.round_count !== 8'(rounds_m) || io.target_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL round_count: count=%0d tv=%0b, expected %0d/0",
                             io.round_count, io.target_valid, rounds_m);
                end
                io.sensor_hit = 1'b0;
            end else if (io.hit_detected || io.miss_pulse || io.target_valid !== (gcyc < p)) begin
                stray++;
            end
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL round_stray: %0d bad cycles, expected 0", stray);
        end
        checks++;
        if (io.start_game !== 1'b1 || io.target_valid !== 1'b0) begin
            errors++;
            $display("FAIL cooldown_exit: start_game=%0b tv=%0b, expected 1/0",
                     io.start_game, io.target_valid);
        end
        prev_t = cur_tgt;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({io.start_game, io.target_valid, io.hit_detected, io.miss_pulse, io.game_over} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: %b, expected 00000",
                     {io.start_game, io.target_valid, io.hit_detected, io.miss_pulse, io.game_over});
        end
        checks++;
        if (io.difficulty_level !== 2'd1) begin
            errors++; $display("FAIL reset_difficulty: %0d, expected 1", io.difficulty_level);
        end
        checks++;
        if (io.round_count !== 8'd0 || io.time_left_s !== 7'd0 || io.target_box !== 3'd0) begin
            errors++;
            $display("FAIL reset_counters: round=%0d time=%0d target=%0d, expected 0/0/0",
                     io.round_count, io.time_left_s, io.target_box);
        end
    endtask

    task automatic test_start();
        do_reset();
        press_start();
        checks++;
        if (io.start_game !== 1'b1 || io.target_valid !== 1'b0 || io.game_over !== 1'b0) begin
            errors++;
            $display("FAIL start_arm: start_game=%0b tv=%0b over=%0b, expected 1/0/0",
                     io.start_game, io.target_valid, io.game_over);
        end
        arm_round(3);
    endtask

    task automatic test_hit();
        finish_round(K_HIT, 10 * TD, -1);
    endtask

    task automatic test_arm_reject();
        int seq [3];
        seq[0] = 7; seq[1] = prev_t; seq[2] = 5;
        for (int i = 0; i < 3; i++) begin
            io.lfsr_value = 3'(seq[i]);
            step();
            checks++;
            if (io.target_valid !== (i == 2) || io.start_game !== 1'b1) begin
                errors++;
                $display("FAIL arm_reject lfsr=%0d: tv=%0b start_game=%0b, expected %0b/1",
                         seq[i], io.target_valid, io.start_game, i == 2);
            end
        end
        checks++;
        if (io.target_box !== 3'd5) begin
            errors++; $display("FAIL arm_reject_target: %0d, expected 5", io.target_box);
        end
        L = gcyc; cur_tgt = 5;
        W = win_of(exp_diff(L - 1));
        X = (L / TD + W) * TD;
        io.lfsr_value = 3'd1;
        finish_round(K_HIT, -1, -1);
    endtask

    task automatic test_miss();
        arm_round(3);
        finish_round(K_WRONG, -1, 2);
        arm_round(rand_tgt());
        finish_round(K_TIMEOUT, -1, -1);
    endtask

    task automatic test_tie();
        arm_round(rand_tgt());
        finish_round(K_TIE, -1, -1);
    endtask

    task automatic test_back_to_back();
        while (gcyc < 700) begin
            arm_round(rand_tgt());
            finish_round($urandom_range(0, 3), -1, -1);
        end
    endtask

    task automatic test_game_over();
        int bad;
        bad = 0;
        io.lfsr_value = 3'd7;
        while (gcyc < 780) begin
            step();
            if (io.target_valid !== 1'b0 || io.start_game !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL arm_hold: %0d bad cycles, expected 0", bad); end
        arm_round(rand_tgt());
        bad = 0;
        while (gcyc < GMS * TD + 1) begin
            if (gcyc == GMS * TD) begin io.sensor_hit = 1'b1; io.sensor_box = 3'(cur_tgt); end
            step();
            if (gcyc <= GMS * TD && (io.hit_detected || io.miss_pulse || io.target_valid !== 1'b1)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL window_before_end: %0d bad cycles, expected 0", bad); end
        checks++;
        if (io.game_over !== 1'b1 || io.start_game !== 1'b0 || io.target_valid !== 1'b0) begin
            errors++;
            $display("FAIL game_over: over=%0b start_game=%0b tv=%0b, expected 1/0/0",
                     io.game_over, io.start_game, io.target_valid);
        end
        checks++;
        if (io.hit_detected !== 1'b0 || io.miss_pulse !== 1'b0) begin
            errors++;
            $display("FAIL over_no_pulse: hit=%0b miss=%0b, expected 0/0", io.hit_detected, io.miss_pulse);
        end
        bad = 0;
        repeat (5) begin
            step();
            if (io.game_over !== 1'b1 || io.hit_detected || io.miss_pulse) bad++;
        end
        checks++;
        if (bad != 0 || io.round_count !== 8'(rounds_m) || io.difficulty_level !== 2'd3) begin
            errors++;
            $display("FAIL over_hold: bad=%0d round=%0d diff=%0d, expected 0/%0d/3",
                     bad, io.round_count, io.difficulty_level, rounds_m);
        end
        io.sensor_hit = 1'b0;
    endtask

    task automatic test_difficulty();
        for (int n = 0; n < 1024; n++) begin
            if (log_v[n]) begin
                checks++;
                if (diff_log[n] !== 2'(exp_diff(n))) begin
                    errors++;
                    $display("FAIL difficulty at cycle %0d: %0d, expected %0d", n, diff_log[n], exp_diff(n));
                end
            end
        end
    endtask

    task automatic test_restart();
        step();
        press_start();
        checks++;
        if (io.start_game !== 1'b1 || io.game_over !== 1'b0 || io.round_count !== 8'd0 ||
            io.difficulty_level !== 2'd1 || io.time_left_s !== 7'd0) begin
            errors++;
            $display("FAIL restart: sg=%0b over=%0b round=%0d diff=%0d time=%0d, expected 1/0/0/1/0",
                     io.start_game, io.game_over, io.round_count, io.difficulty_level, io.time_left_s);
        end
        arm_round(rand_tgt());
    endtask

    task automatic test_reset_mid_game();
        int bad;
        bad = 0;
        step();
        io.sensor_hit = 1'b1;
        io.sensor_box = 3'(cur_tgt);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (io.start_game !== 1'b0 || io.target_valid !== 1'b0 || io.hit_detected !== 1'b0 ||
            io.miss_pulse !== 1'b0 || io.round_count !== 8'd0 || io.difficulty_level !== 2'd1) begin
            errors++;
            $display("FAIL reset_mid_game: sg=%0b tv=%0b hit=%0b miss=%0b round=%0d diff=%0d",
                     io.start_game, io.target_valid, io.hit_detected, io.miss_pulse,
                     io.round_count, io.difficulty_level);
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (io.start_game || io.hit_detected || io.miss_pulse || io.game_over) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL after_reset_idle: %0d bad cycles, expected 0", bad); end
        io.sensor_hit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_arm_reject();
        test_miss();
        test_tie();
        test_back_to_back();
        test_game_over();
        test_difficulty();
        test_restart();
        test_reset_mid_game();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
